// File: rtl/axis_pkg.sv
// axis_pkg: shared beat layout and read-side gate states for the AXI-Stream packet FIFO
package axis_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int KEEP_W_DEFAULT = 4;
  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] tdata;
    logic [KEEP_W_DEFAULT-1:0] tkeep;
    logic                      tlast;
  } axis_beat_t;
  typedef enum logic [1:0] {IDLE, SEND, FORCE} rd_state_e;
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port beat storage with a registered, write-through read port
module axis_fifo_ram #(
  parameter int W     = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk)
    o_rdata <= rst ? '0 : (i_we && i_waddr == i_raddr) ? i_wdata : r_mem[i_raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream FIFO with optional store-and-forward packet release
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter bit PACKET_MODE = 1,
  parameter int KEEP_W      = DATA_W / 8,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              oversize
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = DATA_W + KEEP_W + 1;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_raddr;
  logic [CNT_W-1:0] r_cnt, r_pkt, w_cnt_nxt, w_pkt_nxt;
  logic             r_s_tready, r_m_tvalid, r_oversize, w_wr, w_rd, w_trig, w_open;
  logic [W-1:0]     w_dout;
  rd_state_e        r_state, w_state_nxt;
  assign w_wr    = s_tvalid && r_s_tready;
  assign w_rd    = r_m_tvalid && m_tready;
  assign w_raddr = r_rd_ptr + PTR_W'(w_rd);
  assign w_trig  = PACKET_MODE && r_state == IDLE && r_cnt == CNT_W'(DEPTH) && r_pkt == '0;
  always_comb begin
    w_cnt_nxt   = r_cnt + CNT_W'(w_wr) - CNT_W'(w_rd);
    w_pkt_nxt   = r_pkt + CNT_W'(w_wr && s_tlast) - CNT_W'(w_rd && m_tlast);
    w_state_nxt = w_trig ? FORCE :
                  (w_rd && m_tlast) ? (w_pkt_nxt == '0 ? IDLE : SEND) :
                  (r_state == IDLE && r_pkt != '0 && r_cnt != '0) ? SEND : r_state;
    w_open      = !PACKET_MODE || w_pkt_nxt != '0 || w_state_nxt == FORCE;
  end
  // the RAM read address already points at the next head, so its output register is the m_ beat
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_pkt      <= '0;
      r_state    <= IDLE;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_wr);
      r_rd_ptr   <= w_raddr;
      r_cnt      <= w_cnt_nxt;
      r_pkt      <= w_pkt_nxt;
      r_state    <= PACKET_MODE ? w_state_nxt : IDLE;
      r_s_tready <= w_cnt_nxt != CNT_W'(DEPTH);
      r_m_tvalid <= w_cnt_nxt != '0 && w_open;
      r_oversize <= w_trig;
    end
  axis_fifo_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .i_we(w_wr),
    .i_waddr(r_wr_ptr),
    .i_raddr(w_raddr),
    .i_wdata({s_tdata, s_tkeep, s_tlast}),
    .o_rdata(w_dout)
  );
  assign {m_tdata, m_tkeep, m_tlast} = w_dout;
  assign s_tready  = r_s_tready;
  assign m_tvalid  = r_m_tvalid;
  assign count     = r_cnt;
  assign pkt_count = r_pkt;
  assign oversize  = r_oversize;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: queue-model and directed checks for store-and-forward and cut-through FIFOs
module tb_axis_pkt_fifo;
  import axis_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1;
  logic [31:0] s_tdata = 0, m_tdata, c_tdata = 0, c_m_tdata;
  logic [3:0] s_tkeep = 0, m_tkeep, c_tkeep = 4'hf, c_m_tkeep;
  logic s_tlast = 0, s_tvalid = 0, s_tready, m_tlast, m_tvalid, m_tready = 0, oversize;
  logic c_tlast = 0, c_tvalid = 0, c_s_tready, c_m_tlast, c_m_tvalid, c_m_tready = 0, c_oversize;
  logic [4:0] count, pkt_count, c_count, c_pkt_count;
  int n_tests = 0, n_fail = 0, ov_seen = 0;
  axis_beat_t q[$];
  bit started = 0, rdy_ok = 0, forced = 0, ov_exp = 0, was_rst = 0, wr, rd, trig, rd_last;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_W(32), .DEPTH(DEPTH), .PACKET_MODE(1)) u_dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .count(count),
    .pkt_count(pkt_count), .oversize(oversize));

  axis_pkt_fifo #(.DATA_W(32), .DEPTH(DEPTH), .PACKET_MODE(0)) u_cut (
    .clk(clk), .rst(rst), .s_tdata(c_tdata), .s_tkeep(c_tkeep), .s_tlast(c_tlast),
    .s_tvalid(c_tvalid), .s_tready(c_s_tready), .m_tdata(c_m_tdata), .m_tkeep(c_m_tkeep),
    .m_tlast(c_m_tlast), .m_tvalid(c_m_tvalid), .m_tready(c_m_tready), .count(c_count),
    .pkt_count(c_pkt_count), .oversize(c_oversize));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int npk();
    int n = 0;
    foreach (q[i]) n += int'(q[i].tlast);
    return n;
  endfunction
  function automatic bit exp_rdy();
    return rdy_ok && q.size() != DEPTH;
  endfunction
  function automatic bit exp_val();
    return q.size() != 0 && (npk() != 0 || forced);
  endfunction

  // store-and-forward model: a queue of beats, released only while a whole packet is held or a forced release is active
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      rdy_ok = 0; forced = 0; ov_exp = 0; was_rst = 1; started = 1;
    end else begin
      wr = s_tvalid && exp_rdy();
      rd = exp_val() && m_tready;
      trig = q.size() == DEPTH && npk() == 0 && !forced;
      rd_last = rd && q[0].tlast;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back({s_tdata, s_tkeep, s_tlast});
      forced = trig || (forced && !rd_last);
      ov_exp = trig; rdy_ok = 1; was_rst = 0;
    end
  end

  always @(negedge clk) if (started) begin
    check("s_tready", s_tready, exp_rdy());
    check("m_tvalid", m_tvalid, exp_val());
    check("count", count, q.size());
    check("pkt_count", pkt_count, npk());
    check("oversize", oversize, ov_exp);
    if (exp_val()) check("m_beat", {m_tdata, m_tkeep, m_tlast}, q[0]);
    else if (was_rst) check("m_beat_rst", {m_tdata, m_tkeep, m_tlast}, 0);
    if (oversize) ov_seen++;
  end

  task automatic put(input logic [31:0] d, input logic l);
    int n = 0;
    s_tvalid = 1; s_tdata = d; s_tkeep = 4'hf; s_tlast = l;
    while (!s_tready && n < 100) begin @(negedge clk); n++; end
    check("put_rdy", s_tready, 1);
    @(negedge clk);
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic wait_empty(input string name, input int max);
    int n = 0;
    while (count != 0 && n < max) begin @(negedge clk); n++; end
    check(name, count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_cut_count", c_count, 0);
    check("rst_cut_s_tready", c_s_tready, 0);
    rst = 0;
    @(negedge clk);
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_cut_s_tready", c_s_tready, 1);
    // cut-through: each beat shows one cycle after its write and is consumed the next
    c_m_tready = 1;
    for (int i = 0; i < 4; i++) begin
      c_tvalid = 1; c_tdata = 32'h11 * (i + 1); c_tlast = (i == 3);
      @(negedge clk);
      check("cut_valid", c_m_tvalid, 1);
      check("cut_data", c_m_tdata, 32'h11 * (i + 1));
      check("cut_count", c_count, 1);
    end
    c_tvalid = 0;
    @(negedge clk);
    check("cut_empty_valid", c_m_tvalid, 0);
    check("cut_empty_count", c_count, 0);
    check("cut_empty_pkt", c_pkt_count, 0);
    // three-beat packet held until tlast is written
    m_tready = 1;
    put(32'h101, 0);
    put(32'h102, 0);
    check("sf_held_valid", m_tvalid, 0);
    check("sf_held_count", count, 2);
    put(32'h103, 1);
    check("sf_rel_valid", m_tvalid, 1);
    check("sf_rel_pkt", pkt_count, 1);
    check("sf_rel_data", m_tdata, 32'h101);
    repeat (3) @(negedge clk);
    check("sf_done_count", count, 0);
    check("sf_done_pkt", pkt_count, 0);
    // fill to full, then a one-cycle read must not admit the offered beat
    m_tready = 0;
    put(32'hA1, 0);
    put(32'hA2, 1);
    for (int i = 0; i < 14; i++) put(32'hB0 + i, 0);
    check("full_count", count, 16);
    check("full_s_tready", s_tready, 0);
    s_tvalid = 1; s_tdata = 32'hDEAD; m_tready = 1;
    @(negedge clk);
    s_tvalid = 0; m_tready = 0;
    check("full_rd_count", count, 15);
    check("full_rd_s_tready", s_tready, 1);
    m_tready = 1;
    put(32'hEE, 1);
    wait_empty("full_drain", 40);
    // twenty-beat packet forces a cut-through release
    for (int i = 1; i <= 20; i++) put(32'h3000 + i, i == 20);
    wait_empty("over_drain", 60);
    check("over_pulses", ov_seen, 1);
    put(32'h77, 0);
    check("over_gate_closed", m_tvalid, 0);
    check("over_left_count", count, 1);
    // write-with-tlast and read-with-tlast in the same cycle
    m_tready = 0;
    put(32'hA, 1);
    m_tready = 1;
    @(negedge clk);
    check("sim_pre_count", count, 1);
    check("sim_pre_pkt", pkt_count, 1);
    put(32'hB, 1);
    check("sim_count", count, 1);
    check("sim_pkt", pkt_count, 1);
    check("sim_data", m_tdata, 32'hB);
    @(negedge clk);
    check("sim_done_count", count, 0);
    // reset discards a partial packet
    m_tready = 0;
    for (int i = 0; i < 5; i++) put(32'h500 + i, 0);
    check("mid_count", count, 5);
    rst = 1;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_pkt", pkt_count, 0);
    check("mid_rst_valid", m_tvalid, 0);
    rst = 0;
    @(negedge clk);
    check("mid_post_s_tready", s_tready, 1);
    m_tready = 1;
    put(32'hCAFE, 1);
    check("one_valid", m_tvalid, 1);
    check("one_last", m_tlast, 1);
    check("one_data", m_tdata, 32'hCAFE);
    @(negedge clk);
    check("one_done_count", count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
